ram_loader: RTL and testbench
=============================

Name: ram_loader

Overview:
- Initiator/writer side of the 64x8 single-port RAM (Data, Addr, we, clk, X). The RAM itself is read-only-tested today; this block fills it.
- Accepts a byte stream over a valid/ready handshake and writes it to consecutive RAM addresses starting at a base address.
- Then reads the same region back and compares XOR checksums. Used to load program/data images into processor memory before reset release.

Parameters:
- ADDR_W, 6, RAM address width.
- DATA_W, 8, RAM data width.
- DEPTH, 64, RAM words; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- base_addr  in  ADDR_W  first RAM address, captured on accepted start.
- length  in  ADDR_W+1  byte count 0..DEPTH, captured on accepted start.
- in_data  in  DATA_W  stream byte.
- in_valid  in  1  stream byte valid.
- in_ready  out  1  block can accept a byte.
- ram_data  out  DATA_W  to RAM Data.
- ram_addr  out  ADDR_W  to RAM Addr.
- ram_we  out  1  to RAM we.
- ram_q  in  DATA_W  from RAM X. Combinational read of mem[ram_addr].
- busy  out  1  high in WRITE and VERIFY.
- done  out  1  one-cycle pulse at end of operation.
- error  out  1  result flag; held until the next accepted start.
- checksum  out  DATA_W  XOR of written bytes; held until the next accepted start.

Behaviour:
- Reset values: state=IDLE, in_ready=0, ram_we=0, ram_addr=0, ram_data=0, busy=0, done=0, error=0, checksum=0. Internal pointer, counter and accumulators all 0.
- ram_we is gated by ~rst, so no write commits on any edge where rst=1, including reset asserted mid-WRITE.
- IDLE:
  - start=1 captures base_addr into ptr and length into cnt.
  - Clears error, checksum (wr_xor) and rd_xor.
  - length=0: go to DONE; no writes, error=0.
  - length>DEPTH: go to DONE with error=1; no writes.
  - Otherwise go to WRITE.
- WRITE:
  - in_ready=1; ram_addr=ptr; ram_data=in_data; ram_we=in_valid, all combinational.
  - Transfer occurs when in_valid&&in_ready at a rising edge. On transfer the RAM commits the byte, wr_xor^=in_data, ptr=ptr+1 mod DEPTH, cnt=cnt-1.
  - No transfer: state holds, no write.
  - After the last transfer (cnt 1->0): ptr reloads base_addr, cnt reloads length, go to VERIFY. in_ready=0 from that next cycle.
- VERIFY:
  - ram_we=0; ram_addr=ptr; each cycle rd_xor^=ram_q, ptr increments with wrap, cnt decrements.
  - Exactly length cycles, then go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - error is registered with (wr_xor!=rd_xor), or stays 1 from the length>DEPTH case.
  - checksum=wr_xor.
  - Next state is IDLE.
- Latency: N-byte load with in_valid held high takes N WRITE cycles + N VERIFY cycles + 1 DONE cycle after the start cycle.
- Wrap-around: base_addr=62, length=4 writes addresses 62,63,0,1.
- start while busy or in DONE: ignored.
- busy=1 exactly in WRITE and VERIFY.
- in_valid outside WRITE: ignored; in_ready=0.
- Reset mid-operation: return to IDLE next edge. Bytes already written stay in the RAM; done is not pulsed.

Decomposition:
- Shared package (mem_pkg):
  - ADDR_W/DATA_W/DEPTH constants.
  - State encoding typedef: IDLE=2'd0, WRITE=2'd1, VERIFY=2'd2, DONE=2'd3.
- Single module, no sub-module required.
  - The address pointer/counter pair may optionally be split out as ram_addr_seq (load, increment-with-wrap, zero detect), shared with a future DMA reader.

Test Plan:
- Basic load: start, base=0, len=4, bytes 0x11,0x22,0x44,0x88 with in_valid held high -> RAM[0..3] equal those bytes; done pulses 9 cycles after the start cycle; checksum=0xFF; error=0.
- Back-pressure: same load with in_valid low on alternate cycles -> no ram_we on idle cycles; identical RAM contents; WRITE lasts 8 cycles.
- Wrap-around: base=62, len=4, bytes 0xA0..0xA3 -> RAM[62]=0xA0, RAM[63]=0xA1, RAM[0]=0xA2, RAM[1]=0xA3; error=0.
- Edge lengths:
  - len=0 -> done after 1 cycle, no ram_we, error=0.
  - len=65 -> done, error=1, no ram_we.
  - len=64 -> all 64 addresses written.
- Corruption: bench forces RAM[2] to 0x00 during VERIFY of the basic load -> error=1; checksum still 0xFF.
- Reset mid-WRITE: assert rst after the 2nd byte of a len=4 load -> ram_we=0 on the rst edge; state IDLE; no done pulse; RAM[0..1] written, RAM[2..3] unchanged; a new start then succeeds.

Source files
------------

// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg: shared RAM geometry and loader state encoding.
package ram_loader_pkg;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } state_t;
endpackage

// File: rtl/ram_loader_if.sv
// ram_loader_if: byte stream handshake plus single-port RAM bus seen by the loader.
interface ram_loader_if;
    import ram_loader_pkg::*;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] ram_data;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_q;
    modport master (
        input  in_data, in_valid, ram_q,
        output in_ready, ram_data, ram_addr, ram_we
    );
    modport slave (
        output in_data, in_valid, ram_q,
        input  in_ready, ram_data, ram_addr, ram_we
    );
endinterface

// File: rtl/ram_loader_addr_seq.sv
// ram_loader_addr_seq: address pointer and remaining-count pair with load and wrapping step.
module ram_loader_addr_seq
    import ram_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] load_ptr,
    input  logic [ADDR_W:0]   load_cnt,
    output logic [ADDR_W-1:0] ptr,
    output logic              last
);
    logic [ADDR_W:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            cnt <= '0;
        end else if (load) begin
            ptr <= load_ptr;
            cnt <= load_cnt;
        end else if (step) begin
            ptr <= ptr + ADDR_W'(1);
            cnt <= cnt - (ADDR_W+1)'(1);
        end
    end
    assign last = cnt == (ADDR_W+1)'(1);
endmodule

// File: rtl/ram_loader.sv
// ram_loader: streams bytes into consecutive RAM addresses, then re-reads them and compares XOR checksums.
module ram_loader
    import ram_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    ram_loader_if.master      bus,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] checksum
);
    state_t            state, state_nx;
    logic [ADDR_W-1:0] base_r, ptr, load_ptr;
    logic [ADDR_W:0]   len_r, load_cnt;
    logic [DATA_W-1:0] wr_xor, rd_xor;
    logic              accept, xfer, load, step, last, bad_len;

    assign accept   = state == IDLE && start;
    assign bad_len  = length == '0 || length > (ADDR_W+1)'(DEPTH);
    assign xfer     = state == WRITE && bus.in_valid;
    assign load     = accept || (xfer && last);
    assign step     = xfer || state == VERIFY;
    assign load_ptr = accept ? base_addr : base_r;
    assign load_cnt = accept ? length : len_r;

    ram_loader_addr_seq u_seq (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .load_ptr (load_ptr),
        .load_cnt (load_cnt),
        .ptr      (ptr),
        .last     (last)
    );

    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = start ? (bad_len ? DONE : WRITE) : IDLE;
            WRITE:   state_nx = (xfer && last) ? VERIFY : WRITE;
            VERIFY:  state_nx = last ? DONE : VERIFY;
            default: state_nx = IDLE;
        endcase
    end

    // The write enable is gated by rst so a reset edge mid-WRITE never commits a byte.
    assign busy         = state == WRITE || state == VERIFY;
    assign done         = state == DONE;
    assign bus.in_ready = state == WRITE;
    assign bus.ram_we   = xfer && !rst;
    assign bus.ram_addr = busy ? ptr : '0;
    assign bus.ram_data = state == WRITE ? bus.in_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            base_r   <= '0;
            len_r    <= '0;
            wr_xor   <= '0;
            rd_xor   <= '0;
            error    <= 1'b0;
            checksum <= '0;
        end else begin
            if (accept) begin
                base_r   <= base_addr;
                len_r    <= length;
                wr_xor   <= '0;
                rd_xor   <= '0;
                checksum <= '0;
                error    <= length > (ADDR_W+1)'(DEPTH);
            end
            if (xfer) wr_xor <= wr_xor ^ bus.in_data;
            if (state == VERIFY) rd_xor <= rd_xor ^ bus.ram_q;
            if (state == DONE) begin
                error    <= error | (wr_xor != rd_xor);
                checksum <= wr_xor;
            end
        end
    end
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: vector table of loads scored against write and result queues, plus reset and idle corner cases.
module tb_ram_loader;
    import ram_loader_pkg::*;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [ADDR_W:0]   len;
        logic [31:0]       data;
        bit                gap;
        bit                corrupt;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   length = '0;
    logic              busy, done, error;
    logic [DATA_W-1:0] checksum;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              clr = 1'b0;
    logic              corrupt = 1'b0;
    logic [DATA_W-1:0] fill = '0;

    int   n_cmp = 0;
    int   n_bad = 0;
    wr_t  wq[$];
    logic [DATA_W:0] rq[$];
    vec_t vt[8];

    ram_loader_if bus();

    ram_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    assign bus.ram_q = mem[bus.ram_addr];

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= fill;
        end else begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_data;
            if (corrupt) mem[2] <= 8'h00;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Every committed write must match the oldest byte the driver offered.
    always @(negedge clk) begin
        if (bus.ram_we) begin
            if (wq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h, required no write", bus.ram_addr, bus.ram_data);
            end else begin
                wr_t e;
                e = wq.pop_front();
                chk("write_addr", 32'(bus.ram_addr), 32'(e.a));
                chk("write_data", 32'(bus.ram_data), 32'(e.d));
            end
        end
    end

    function automatic logic [7:0] byte_of(input vec_t v, input int i);
        return i < 4 ? v.data[8*i +: 8] : 8'(i * 7 + 3);
    endfunction

    task automatic run(input vec_t v, input string tag);
        int n, idx, k, exp_cyc;
        bit ok_len, seen, ram_ok;
        logic [7:0] ck;
        logic [DATA_W:0] r;
        n = int'(v.len);
        ok_len = n >= 1 && n <= DEPTH;
        ck = '0;
        idx = 0;
        seen = 0;
        if (ok_len) for (int i = 0; i < n; i++) ck ^= byte_of(v, i);
        exp_cyc = !ok_len ? 1 : (v.gap ? 3 * n + 1 : 2 * n + 1);
        rq.push_back({(n > DEPTH) || v.corrupt, ck});
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = v.base;
        length = v.len;
        @(posedge clk); #1;
        start = 1'b0;
        for (k = 1; k <= 250; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            bus.in_valid = 1'b0;
            if (ok_len && idx < n && (!v.gap || k % 2 == 0)) begin
                bus.in_valid = 1'b1;
                bus.in_data = byte_of(v, idx);
                wq.push_back('{a: 6'(int'(v.base) + idx), d: byte_of(v, idx)});
                idx++;
            end
            corrupt = v.corrupt && k == 5;
            if (k == 1) chk({tag, "_busy_first"}, 32'(busy), 32'(ok_len));
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        bus.in_valid = 1'b0;
        corrupt = 1'b0;
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, "_latency"}, 32'(k), 32'(exp_cyc));
            @(negedge clk);
            r = rq.pop_front();
            chk({tag, "_done_pulse"}, 32'(done), 32'd0);
            chk({tag, "_busy_after"}, 32'(busy), 32'd0);
            chk({tag, "_error"}, 32'(error), 32'(r[DATA_W]));
            chk({tag, "_checksum"}, 32'(checksum), 32'(r[DATA_W-1:0]));
        end
        if (ok_len && !v.corrupt) begin
            ram_ok = 1;
            for (int i = 0; i < n; i++)
                if (mem[6'(int'(v.base) + i)] !== byte_of(v, i)) ram_ok = 0;
            chk({tag, "_ram"}, 32'(ram_ok), 32'd1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit quiet;
        vt[0] = '{base: 6'd0,  len: 7'd4,  data: 32'h88442211, gap: 0, corrupt: 0};
        vt[1] = '{base: 6'd0,  len: 7'd4,  data: 32'h88442211, gap: 1, corrupt: 0};
        vt[2] = '{base: 6'd62, len: 7'd4,  data: 32'hA3A2A1A0, gap: 0, corrupt: 0};
        vt[3] = '{base: 6'd5,  len: 7'd0,  data: 32'h0,        gap: 0, corrupt: 0};
        vt[4] = '{base: 6'd0,  len: 7'd65, data: 32'h0,        gap: 0, corrupt: 0};
        vt[5] = '{base: 6'd17, len: 7'd64, data: 32'h0F1E2D3C, gap: 0, corrupt: 0};
        vt[6] = '{base: 6'd0,  len: 7'd4,  data: 32'h88442211, gap: 0, corrupt: 1};
        vt[7] = '{base: 6'd63, len: 7'd1,  data: 32'h0000005A, gap: 0, corrupt: 0};
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;

        clr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_flags", 32'({bus.in_ready, bus.ram_we, busy, done, error}), 32'd0);
        chk("reset_addr", 32'(bus.ram_addr), 32'd0);
        chk("reset_data", 32'(bus.ram_data), 32'd0);
        chk("reset_checksum", 32'(checksum), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        clr = 1'b0;

        for (int i = 0; i < 8; i++) run(vt[i], $sformatf("vec%0d", i));

        // Stream bytes offered while idle must be refused and never written.
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h77;
        repeat (3) begin
            @(negedge clk);
            chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;

        // Reset after two bytes of a four-byte load.
        clr = 1'b1;
        fill = 8'hEE;
        @(posedge clk); #1;
        clr = 1'b0;
        start = 1'b1;
        base_addr = 6'd0;
        length = 7'd4;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 8'(8'h31 + i);
            wq.push_back('{a: 6'(i), d: 8'(8'h31 + i)});
            @(posedge clk); #1;
        end
        rst = 1'b1;
        bus.in_data = 8'h33;
        @(negedge clk);
        chk("rst_we_gated", 32'(bus.ram_we), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        quiet = 1;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) quiet = 0;
        end
        chk("rst_no_done", 32'(quiet), 32'd1);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_ram0", 32'(mem[0]), 32'h31);
        chk("rst_ram1", 32'(mem[1]), 32'h32);
        chk("rst_ram2", 32'(mem[2]), 32'hEE);
        chk("rst_ram3", 32'(mem[3]), 32'hEE);
        run(vt[0], "after_rst");

        chk("write_queue_empty", 32'(wq.size()), 32'd0);
        chk("result_queue_empty", 32'(rq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
